// File: rtl/adsr_poly.sv
// Polyphonic ADSR envelope generator and voice mixer with a 3-stage sample pipeline.
// Build option ADSR_MIX_SATURATE_EN: clamp the mix sum instead of averaging it.
module adsr_poly #(
  parameter int NUM_VOICES   = 4,
  parameter int SAMPLE_WIDTH = 16,
  parameter int ENV_WIDTH    = 16
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               in_ready,
  input  logic [NUM_VOICES*SAMPLE_WIDTH-1:0] sample_in,
  input  logic [NUM_VOICES-1:0]              gate,
  input  logic [ENV_WIDTH-1:0]               attack_step,
  input  logic [ENV_WIDTH-1:0]               decay_step,
  input  logic [ENV_WIDTH-1:0]               sustain_level,
  input  logic [ENV_WIDTH-1:0]               release_step,
  output logic [SAMPLE_WIDTH-1:0]            sample_out,
  output logic                               out_valid,
  output logic [NUM_VOICES-1:0]              voice_active,
  output logic [NUM_VOICES*3-1:0]            voice_state,
  output logic [NUM_VOICES*ENV_WIDTH-1:0]    voice_env
);

  // Handshake: in_ready is a one-cycle tick strobe with no back-pressure; every
  // tick yields exactly one out_valid pulse three cycles later, in order.

  localparam int LOG_V = $clog2(NUM_VOICES);
  localparam int ACC_W = SAMPLE_WIDTH + LOG_V;
  localparam logic [ENV_WIDTH:0] ENV_MAX = {1'b0, {ENV_WIDTH{1'b1}}};

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ATTACK  = 3'd1,
    ST_DECAY   = 3'd2,
    ST_SUSTAIN = 3'd3,
    ST_RELEASE = 3'd4
  } state_t;

  logic [NUM_VOICES*SAMPLE_WIDTH-1:0] scaled_bus;
  logic                               valid_s1;
  logic                               valid_s2;

  for (genvar i = 0; i < NUM_VOICES; i++) begin : gen_voice
    state_t                          state;
    logic [ENV_WIDTH-1:0]            env;
    logic signed [SAMPLE_WIDTH-1:0]  samp_q;
    logic signed [SAMPLE_WIDTH-1:0]  scaled_q;
    logic [ENV_WIDTH:0]              atk_sum;
    logic                            atk_done;
    logic                            dec_done;
    logic                            rel_done;
    logic signed [SAMPLE_WIDTH+ENV_WIDTH:0] samp_ext;
    logic signed [SAMPLE_WIDTH+ENV_WIDTH:0] env_ext;

    // Threshold tests run one bit wider than env so the sums cannot wrap.
    assign atk_sum  = {1'b0, env} + {1'b0, attack_step};
    assign atk_done = atk_sum >= ENV_MAX;
    assign dec_done = {1'b0, env} <= ({1'b0, sustain_level} + {1'b0, decay_step});
    assign rel_done = env <= release_step;

    assign samp_ext = {{(ENV_WIDTH+1){samp_q[SAMPLE_WIDTH-1]}}, samp_q};
    assign env_ext  = {{SAMPLE_WIDTH{1'b0}}, 1'b0, env};

    always_ff @(posedge clk) begin
      if (reset) begin
        state    <= ST_IDLE;
        env      <= '0;
        samp_q   <= '0;
        scaled_q <= '0;
      end else begin
        if (in_ready) begin
          samp_q <= sample_in[i*SAMPLE_WIDTH +: SAMPLE_WIDTH];
          case (state)
            ST_IDLE: begin
              if (gate[i]) state <= ST_ATTACK;
              else         env   <= '0;
            end
            ST_ATTACK: begin
              if (!gate[i]) begin
                state <= ST_RELEASE;
              end else if (atk_done) begin
                env   <= ENV_MAX[ENV_WIDTH-1:0];
                state <= ST_DECAY;
              end else begin
                env <= atk_sum[ENV_WIDTH-1:0];
              end
            end
            ST_DECAY: begin
              if (!gate[i]) begin
                state <= ST_RELEASE;
              end else if (dec_done) begin
                env   <= sustain_level;
                state <= ST_SUSTAIN;
              end else begin
                env <= env - decay_step;
              end
            end
            ST_SUSTAIN: begin
              if (!gate[i]) state <= ST_RELEASE;
              else          env   <= sustain_level;
            end
            ST_RELEASE: begin
              // A retrigger resumes attack from wherever the release had reached.
              if (gate[i]) begin
                state <= ST_ATTACK;
              end else if (rel_done) begin
                env   <= '0;
                state <= ST_IDLE;
              end else begin
                env <= env - release_step;
              end
            end
            default: begin
              state <= ST_IDLE;
              env   <= '0;
            end
          endcase
        end
        scaled_q <= (state == ST_IDLE) ? '0
                  : SAMPLE_WIDTH'((samp_ext * env_ext) >>> ENV_WIDTH);
      end
    end

    assign voice_state[i*3 +: 3]                = state;
    assign voice_env[i*ENV_WIDTH +: ENV_WIDTH]  = env;
    assign voice_active[i]                      = state != ST_IDLE;
    assign scaled_bus[i*SAMPLE_WIDTH +: SAMPLE_WIDTH] = scaled_q;
  end

  logic signed [ACC_W-1:0]        acc;
  logic signed [SAMPLE_WIDTH-1:0] mix;

  always_comb begin
    acc = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      acc = acc + ACC_W'($signed(scaled_bus[i*SAMPLE_WIDTH +: SAMPLE_WIDTH]));
    end
  end

`ifdef ADSR_MIX_SATURATE_EN
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((64'sd1 <<< (SAMPLE_WIDTH-1)) - 64'sd1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = -SAT_MAX - ACC_W'(1);

  always_comb begin
    if (acc > SAT_MAX)      mix = SAMPLE_WIDTH'(SAT_MAX);
    else if (acc < SAT_MIN) mix = SAMPLE_WIDTH'(SAT_MIN);
    else                    mix = SAMPLE_WIDTH'(acc);
  end
`else
  // Dividing by the voice-count headroom keeps the full-scale mix in range.
  assign mix = SAMPLE_WIDTH'(acc >>> LOG_V);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_s1   <= 1'b0;
      valid_s2   <= 1'b0;
      out_valid  <= 1'b0;
      sample_out <= '0;
    end else begin
      valid_s1  <= in_ready;
      valid_s2  <= valid_s1;
      out_valid <= valid_s2;
      if (valid_s2) sample_out <= mix;
    end
  end

endmodule

// File: tb/tb_adsr_poly.sv
// Self-checking bench for adsr_poly (2 voices, 8-bit envelope): table-driven
// envelope walk plus directed scaling, overflow, back-to-back and reset cases.
module tb_adsr_poly;

  localparam int NV = 2;
  localparam int SW = 16;
  localparam int EW = 8;

`ifdef ADSR_MIX_SATURATE_EN
  localparam logic [15:0] EXP_4000 = 16'd16320;
  localparam logic [15:0] EXP_POS  = 16'd32767;
  localparam logic [15:0] EXP_NEG  = 16'h8000;
`else
  localparam logic [15:0] EXP_4000 = 16'd8160;
  localparam logic [15:0] EXP_POS  = 16'd28560;
  localparam logic [15:0] EXP_NEG  = 16'h9070;
`endif

  logic              clk;
  logic              reset;
  logic              in_ready;
  logic [NV*SW-1:0]  sample_in;
  logic [NV-1:0]     gate;
  logic [EW-1:0]     attack_step;
  logic [EW-1:0]     decay_step;
  logic [EW-1:0]     sustain_level;
  logic [EW-1:0]     release_step;
  logic [SW-1:0]     sample_out;
  logic              out_valid;
  logic [NV-1:0]     voice_active;
  logic [NV*3-1:0]   voice_state;
  logic [NV*EW-1:0]  voice_env;

  adsr_poly #(.NUM_VOICES(NV), .SAMPLE_WIDTH(SW), .ENV_WIDTH(EW)) dut (
    .clk           (clk),
    .reset         (reset),
    .in_ready      (in_ready),
    .sample_in     (sample_in),
    .gate          (gate),
    .attack_step   (attack_step),
    .decay_step    (decay_step),
    .sustain_level (sustain_level),
    .release_step  (release_step),
    .sample_out    (sample_out),
    .out_valid     (out_valid),
    .voice_active  (voice_active),
    .voice_state   (voice_state),
    .voice_env     (voice_env)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  logic [SW-1:0] exp_q[$];
  int            n_cmp = 0;
  int            n_err = 0;
  int            n_valid = 0;
  int            first_cyc = 0;
  int            last_cyc = 0;
  logic          mon_en = 1'b0;
  logic [SW-1:0] held = '0;

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [15:0] exp_mix(input logic [15:0] s0, input int e0,
                                          input logic [15:0] s1, input int e1);
    longint p0, p1, sum;
    p0  = (longint'($signed(s0)) * e0) >>> 8;
    p1  = (longint'($signed(s1)) * e1) >>> 8;
    sum = p0 + p1;
`ifdef ADSR_MIX_SATURATE_EN
    if (sum > 32767)       sum = 32767;
    else if (sum < -32768) sum = -32768;
`else
    sum = sum >>> 1;
`endif
    return sum[15:0];
  endfunction

  always @(negedge clk) begin
    if (mon_en) begin
      if (out_valid) begin
        n_valid++;
        if (n_valid == 1) first_cyc = cyc;
        last_cyc = cyc;
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_valid: got %0d expected no output", sample_out);
        end else begin
          logic [SW-1:0] e;
          e = exp_q.pop_front();
          check("sample_out", sample_out, e);
          held = e;
        end
      end else begin
        check("sample_hold", sample_out, held);
      end
      if (reset) held = '0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input logic [1:0] g, input logic [15:0] s0, input logic [15:0] s1,
                      input logic [15:0] e);
    gate      = g;
    sample_in = {s1, s0};
    in_ready  = 1'b1;
    exp_q.push_back(e);
    @(posedge clk); #1;
    in_ready  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    in_ready = 1'b0;
    gate     = '0;
    @(posedge clk); #1;
    exp_q.delete();
    reset    = 1'b0;
  endtask

  task automatic set_steps(input logic [7:0] a, input logic [7:0] d,
                           input logic [7:0] s, input logic [7:0] r);
    attack_step   = a;
    decay_step    = d;
    sustain_level = s;
    release_step  = r;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [1:0] g;
    logic [7:0] atk, dec, sus, rel;
    logic [2:0] st0;
    logic [7:0] env0;
  } vec_t;

  vec_t vecs[20];

  initial begin
    logic [15:0] s0, s1;
    int lat;

    vecs[0]  = '{2'b01, 8'd64, 8'd50, 8'd100, 8'd30, 3'd1, 8'd0};
    vecs[1]  = '{2'b01, 8'd64, 8'd50, 8'd100, 8'd30, 3'd1, 8'd64};
    vecs[2]  = '{2'b01, 8'd64, 8'd50, 8'd100, 8'd30, 3'd1, 8'd128};
    vecs[3]  = '{2'b01, 8'd64, 8'd50, 8'd100, 8'd30, 3'd1, 8'd192};
    vecs[4]  = '{2'b01, 8'd64, 8'd50, 8'd100, 8'd30, 3'd2, 8'd255};
    vecs[5]  = '{2'b01, 8'd64, 8'd50, 8'd100, 8'd30, 3'd2, 8'd205};
    vecs[6]  = '{2'b01, 8'd64, 8'd50, 8'd100, 8'd30, 3'd2, 8'd155};
    vecs[7]  = '{2'b01, 8'd64, 8'd50, 8'd100, 8'd30, 3'd2, 8'd105};
    vecs[8]  = '{2'b01, 8'd64, 8'd50, 8'd100, 8'd30, 3'd3, 8'd100};
    vecs[9]  = '{2'b01, 8'd64, 8'd50, 8'd80,  8'd30, 3'd3, 8'd80};
    vecs[10] = '{2'b00, 8'd64, 8'd50, 8'd80,  8'd30, 3'd4, 8'd80};
    vecs[11] = '{2'b00, 8'd64, 8'd50, 8'd80,  8'd30, 3'd4, 8'd50};
    vecs[12] = '{2'b00, 8'd64, 8'd50, 8'd80,  8'd30, 3'd4, 8'd20};
    vecs[13] = '{2'b01, 8'd64, 8'd50, 8'd80,  8'd30, 3'd1, 8'd20};
    vecs[14] = '{2'b01, 8'd64, 8'd50, 8'd80,  8'd30, 3'd1, 8'd84};
    vecs[15] = '{2'b00, 8'd64, 8'd50, 8'd80,  8'd30, 3'd4, 8'd84};
    vecs[16] = '{2'b00, 8'd64, 8'd50, 8'd80,  8'd30, 3'd4, 8'd54};
    vecs[17] = '{2'b00, 8'd64, 8'd50, 8'd80,  8'd30, 3'd4, 8'd24};
    vecs[18] = '{2'b00, 8'd64, 8'd50, 8'd80,  8'd30, 3'd0, 8'd0};
    vecs[19] = '{2'b00, 8'd64, 8'd50, 8'd80,  8'd30, 3'd0, 8'd0};

    reset = 1'b1;
    in_ready = 1'b0;
    sample_in = '0;
    gate = '0;
    set_steps(8'd0, 8'd0, 8'd0, 8'd0);
    idle(3);
    check("rst_sample_out", sample_out, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_voice_active", voice_active, 0);
    check("rst_voice_state", voice_state, 0);
    check("rst_voice_env", voice_env, 0);
    reset = 1'b0;
    mon_en = 1'b1;

    // Envelope walk on voice 0, one tick every 4 cycles.
    for (int i = 0; i < 20; i++) begin
      s0 = 16'($urandom_range(0, 65535));
      s1 = 16'($urandom_range(0, 65535));
      set_steps(vecs[i].atk, vecs[i].dec, vecs[i].sus, vecs[i].rel);
      tick(vecs[i].g, s0, s1, exp_mix(s0, int'(vecs[i].env0), s1, 0));
      check($sformatf("v0_state[%0d]", i), voice_state[2:0], vecs[i].st0);
      check($sformatf("v0_env[%0d]", i), voice_env[7:0], vecs[i].env0);
      check($sformatf("v1_state[%0d]", i), voice_state[5:3], 0);
      check($sformatf("active[%0d]", i), voice_active, {1'b0, vecs[i].st0 != 3'd0});
      idle(3);
    end
    idle(4);
    check("table_drain", exp_q.size(), 0);

    // Scaling and latency: voice0 at full envelope, voice1 idle.
    do_reset();
    set_steps(8'd255, 8'd0, 8'd255, 8'd0);
    tick(2'b01, 16'h0000, 16'h0000, 16'h0000);
    tick(2'b01, 16'h0000, 16'h0000, 16'h0000);
    idle(5);
    tick(2'b01, 16'h4000, 16'h1234, EXP_4000);
    lat = 0;
    while (!out_valid && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    check("latency", lat + 1, 3);
    check("scale_state", voice_state, 6'b000_011);
    idle(3);

    // Negative truncation toward minus infinity: -1 at env 1.
    do_reset();
    set_steps(8'd1, 8'd0, 8'd255, 8'd0);
    tick(2'b01, 16'h0000, 16'h0000, 16'h0000);
    tick(2'b01, 16'hFFFF, 16'h0000, 16'hFFFF);
    check("neg_env", voice_env[7:0], 1);
    idle(5);

    // Mix overflow in both directions, both voices at full envelope.
    do_reset();
    set_steps(8'd255, 8'd0, 8'd255, 8'd0);
    tick(2'b11, 16'h0000, 16'h0000, 16'h0000);
    tick(2'b11, 16'h7000, 16'h7000, EXP_POS);
    tick(2'b11, 16'h9000, 16'h9000, EXP_NEG);
    check("ovf_state", voice_state, 6'b011_011);
    check("ovf_env", voice_env, 16'hFFFF);
    idle(5);

    // Back-to-back: six consecutive ticks.
    n_valid = 0;
    gate = 2'b11;
    for (int i = 0; i < 6; i++) begin
      s0 = 16'($urandom_range(0, 65535));
      s1 = 16'($urandom_range(0, 65535));
      sample_in = {s1, s0};
      in_ready = 1'b1;
      exp_q.push_back(exp_mix(s0, 255, s1, 255));
      @(posedge clk); #1;
    end
    in_ready = 1'b0;
    idle(6);
    check("b2b_count", n_valid, 6);
    check("b2b_span", last_cyc - first_cyc, 5);
    check("b2b_drain", exp_q.size(), 0);

    // Reset in the cycle after the third of a burst of ticks.
    n_valid = 0;
    for (int i = 0; i < 3; i++) begin
      s0 = 16'($urandom_range(0, 65535));
      s1 = 16'($urandom_range(0, 65535));
      sample_in = {s1, s0};
      in_ready = 1'b1;
      exp_q.push_back(exp_mix(s0, 255, s1, 255));
      @(posedge clk); #1;
    end
    reset = 1'b1;
    in_ready = 1'b0;
    @(posedge clk); #1;
    exp_q.delete();
    check("mrst_sample_out", sample_out, 0);
    check("mrst_out_valid", out_valid, 0);
    check("mrst_voice_active", voice_active, 0);
    check("mrst_voice_env", voice_env, 0);
    reset = 1'b0;
    idle(8);
    check("mrst_valid_count", n_valid, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
